// File: rtl/vx_operands_dispatch.sv
// Operand dispatch: 2-entry skid FIFO steering packets to execute lanes.
// Optional perf counters enabled by defining VX_DISPATCH_PERF_EN.
module vx_operands_dispatch #(
  parameter int DATA_W       = 512,
  parameter int EX_BITS      = 2,
  parameter int EX_LSB       = 0,
  parameter int NUM_EX_UNITS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    operands_valid,
  input  logic [DATA_W-1:0]       operands_data,
  output logic                    operands_ready,
  output logic [NUM_EX_UNITS-1:0] execute_valid,
  output logic [DATA_W-1:0]       execute_data,
  input  logic [NUM_EX_UNITS-1:0] execute_ready,
  output logic                    bad_ex_type,
`ifdef VX_DISPATCH_PERF_EN
  output logic [NUM_EX_UNITS*32-1:0] perf_stalls,
  output logic [31:0]             perf_issued,
`endif
  output logic                    busy
);

  localparam logic [EX_BITS:0] NUM_EX_L =
    (EX_BITS+1)'(NUM_EX_UNITS);

  logic [DATA_W-1:0]  mem_q [2];
  logic [DATA_W-1:0]  mem_d [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               rdy_q, rdy_d;
  logic               bad_q, bad_d;

  logic [DATA_W-1:0]  head;
  logic [EX_BITS-1:0] lane;
  logic               head_vld;
  logic               lane_ok;
  logic               push;
  logic               pop;
  logic               hs;
  logic               drop;

  assign head     = mem_q[rd_ptr_q];
  assign lane     = head[EX_LSB +: EX_BITS];
  assign head_vld = (cnt_q != 2'd0);
  assign lane_ok  = ({1'b0, lane} < NUM_EX_L);
  assign push     = operands_valid & rdy_q;
  assign hs       = |(execute_valid & execute_ready);
  assign drop     = head_vld & ~lane_ok;
  assign pop      = hs | drop;

  assign operands_ready = rdy_q;
  assign execute_data   = head;
  assign bad_ex_type    = bad_q;
  assign busy           = head_vld;

  // One-hot lane valid from the decoded head ex_type
  always_comb begin
    execute_valid = '0;
    for (int i = 0; i < NUM_EX_UNITS; i++) begin
      if (head_vld && lane_ok && lane == EX_BITS'(i))
        execute_valid[i] = 1'b1;
    end
  end

  // FIFO next state; ready looks at next count only
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = operands_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop)
      rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
    rdy_d = (cnt_d < 2'd2);
    bad_d = bad_q | drop;
  end

  // FIFO and status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      rdy_q    <= 1'b1;
      bad_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rdy_q    <= rdy_d;
      bad_q    <= bad_d;
    end
  end

`ifdef VX_DISPATCH_PERF_EN
  logic [NUM_EX_UNITS-1:0][31:0] stall_q, stall_d;
  logic [31:0]                   iss_q, iss_d;

  assign perf_stalls = stall_q;
  assign perf_issued = iss_q;

  // Saturating per-lane stall counts, wrapping issue count
  always_comb begin
    stall_d = stall_q;
    for (int i = 0; i < NUM_EX_UNITS; i++) begin
      if (execute_valid[i] && !execute_ready[i]
          && stall_q[i] != '1)
        stall_d[i] = stall_q[i] + 32'd1;
    end
    iss_d = iss_q + 32'(hs);
  end

  // Perf counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      iss_q   <= '0;
    end else begin
      stall_q <= stall_d;
      iss_q   <= iss_d;
    end
  end
`endif

endmodule
